// File: rtl/addsub_serial_bf_if.sv
// rtl/addsub_serial_bf_if.sv - operand/result handshake bundle for the digit-serial adder/subtractor
interface addsub_serial_bf_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             v;

    // Requester side: issues operands, consumes results
    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, s, c, v
    );

    // Arithmetic block side
    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, s, c, v
    );
endinterface

// File: rtl/addsub_serial_bf.sv
// rtl/addsub_serial_bf.sv - digit-serial two's-complement adder/subtractor, LSB digit first
module addsub_serial_bf #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    addsub_serial_bf_if.slave  bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_s;
    logic             r_c;
    logic             r_v;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_accept;
    logic             w_last;
    logic [DIGIT:0]   w_digit_sum;
    logic             w_carry_msb;
    logic [WIDTH-1:0] w_digit_w;
    logic [WIDTH-1:0] w_sum_nxt;

    assign w_accept = (r_state == S_IDLE) && bus.in_valid;
    assign w_last   = (r_cnt == CW'(N - 1));

    // State register; reset abandons any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake decode, driven only by the registered state
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // One digit of ripple add; carry into the digit MSB recovered from sum ^ a ^ b
    always_comb begin
        w_digit_sum = {1'b0, r_a_sh[DIGIT-1:0]}
                    + {1'b0, r_b_sh[DIGIT-1:0]}
                    + {{DIGIT{1'b0}}, r_carry};
        w_carry_msb = w_digit_sum[DIGIT-1] ^ r_a_sh[DIGIT-1] ^ r_b_sh[DIGIT-1];
        w_digit_w   = '0;
        w_digit_w[DIGIT-1:0] = w_digit_sum[DIGIT-1:0];
        w_sum_nxt   = (r_sum >> DIGIT) | (w_digit_w << (WIDTH - DIGIT));
    end

    // Operand shifters, carry chain, result accumulator and digit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a_sh  <= bus.a;
            r_b_sh  <= bus.b ^ {WIDTH{bus.sub}};
            r_carry <= bus.sub;
            r_sum   <= '0;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_a_sh  <= r_a_sh >> DIGIT;
            r_b_sh  <= r_b_sh >> DIGIT;
            r_sum   <= w_sum_nxt;
            r_carry <= w_digit_sum[DIGIT];
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    // Output registers load once on the final digit so s/c/v stay quiet in DONE and after
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s <= '0;
            r_c <= 1'b0;
            r_v <= 1'b0;
        end else if ((r_state == S_RUN) && w_last) begin
            r_s <= w_sum_nxt;
            r_c <= w_digit_sum[DIGIT];
            r_v <= w_carry_msb ^ w_digit_sum[DIGIT];
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.s         = r_s;
    assign bus.c         = r_c;
    assign bus.v         = r_v;
endmodule
